// File: rtl/spram_ctl.sv
// Single-port RAM with nibble write mask, valid/ready access
// and a sequenced active/standby/sleep power controller.
module spram_ctl #(
  parameter int DW         = 16,
  parameter int AW         = 14,
  parameter int WAKE_STBY  = 2,
  parameter int WAKE_SLEEP = 8,
  localparam int MW        = DW / 4
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          REQ,
  input  logic          WE,
  input  logic [AW-1:0] AD,
  input  logic [DW-1:0] DI,
  input  logic [MW-1:0] MASKWE,
  input  logic [1:0]    PWR_REQ,
  output logic          RDY,
  output logic          VLD,
  output logic [DW-1:0] DO,
  output logic [1:0]    PWR_ST
);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    STBY   = 2'd1,
    SLEEP  = 2'd2,
    WAKE   = 2'd3
  } pwr_t;

  localparam logic [3:0] LD_STBY  = 4'(WAKE_STBY - 1);
  localparam logic [3:0] LD_SLEEP = 4'(WAKE_SLEEP - 1);

  logic [DW-1:0] mem [2**AW];

  pwr_t       state;
  pwr_t       state_n;
  logic [3:0] cnt;
  logic [3:0] cnt_n;

  logic req_act;
  logic req_stby;
  logic req_sleep;
  logic acc;
  logic wr_acc;
  logic rd_acc;
  logic to_sleep;

  // PWR_REQ = 3 behaves as sleep
  assign req_act   = (PWR_REQ == 2'd0);
  assign req_stby  = (PWR_REQ == 2'd1);
  assign req_sleep = PWR_REQ[1];

  assign RDY    = (state == ACTIVE) && req_act;
  assign PWR_ST = state;

  assign acc    = REQ && RDY && !RST;
  assign wr_acc = acc && WE;
  assign rd_acc = acc && !WE;

  assign to_sleep = (state_n == SLEEP)
                 && (state != SLEEP);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ACTIVE: begin
        if (req_stby) begin
          state_n = STBY;
        end else if (req_sleep) begin
          state_n = SLEEP;
        end
      end
      STBY: begin
        if (req_sleep) begin
          state_n = SLEEP;
        end else if (req_act) begin
          state_n = WAKE;
          cnt_n   = LD_STBY;
        end
      end
      SLEEP: begin
        if (req_stby) begin
          state_n = STBY;
        end else if (req_act) begin
          state_n = WAKE;
          cnt_n   = LD_SLEEP;
        end
      end
      WAKE: begin
        if (req_sleep) begin
          state_n = SLEEP;
          cnt_n   = 4'd0;
        end else if (req_stby) begin
          state_n = STBY;
          cnt_n   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_n = ACTIVE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        state_n = ACTIVE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state <= ACTIVE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Array is never reset; contents survive RST and all power states
  always_ff @(posedge CK) begin
    if (wr_acc) begin
      for (int i = 0; i < MW; i++) begin
        if (MASKWE[i]) begin
          mem[AD][4*i +: 4] <= DI[4*i +: 4];
        end
      end
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      DO  <= '0;
      VLD <= 1'b0;
    end else begin
      VLD <= rd_acc;
      if (rd_acc) begin
        DO <= mem[AD];
      end else if (to_sleep) begin
        DO <= '0;
      end
    end
  end

endmodule
